// File: rtl/memory_pipe_stages_if.sv
// Bus between the memory1 pipe register, the memory pipe, the writeback/regfile
// logic and the decode-side bypass/hazard consumers.
interface memory_pipe_stages_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  stall;
  logic                  flush;
  logic [DATA_WIDTH-1:0] ALU_result_memory1;
  logic                  opwrite_memory1;
  logic                  opSel_memory1;
  logic [4:0]            opReg_memory1;
  logic [1:0]            next_PC_select_memory1;
  logic [DATA_WIDTH-1:0] instruction_memory1;
  logic [DATA_WIDTH-1:0] load_data_last;
  logic [4:0]            rs1_decode;
  logic [4:0]            rs2_decode;

  logic [DATA_WIDTH-1:0] ALU_result_writeback;
  logic [DATA_WIDTH-1:0] load_data_writeback;
  logic                  opwrite_writeback;
  logic                  opSel_writeback;
  logic [4:0]            opReg_writeback;
  logic [1:0]            next_PC_select_writeback;
  logic [DATA_WIDTH-1:0] instruction_writeback;
  logic [DATA_WIDTH-1:0] bypass_data_last;
  logic                  opwrite_last;
  logic [4:0]            opReg_last;
  logic [1:0]            next_PC_select_last;
  logic                  rs1_fwd_hit;
  logic                  rs2_fwd_hit;
  logic [DATA_WIDTH-1:0] rs1_fwd_data;
  logic [DATA_WIDTH-1:0] rs2_fwd_data;
  logic                  rs1_fwd_stall;
  logic                  rs2_fwd_stall;

  modport master (
    output stall, flush, ALU_result_memory1, opwrite_memory1, opSel_memory1,
           opReg_memory1, next_PC_select_memory1, instruction_memory1,
           load_data_last, rs1_decode, rs2_decode,
    input  ALU_result_writeback, load_data_writeback, opwrite_writeback,
           opSel_writeback, opReg_writeback, next_PC_select_writeback,
           instruction_writeback, bypass_data_last, opwrite_last, opReg_last,
           next_PC_select_last, rs1_fwd_hit, rs2_fwd_hit, rs1_fwd_data,
           rs2_fwd_data, rs1_fwd_stall, rs2_fwd_stall
  );

  modport slave (
    input  stall, flush, ALU_result_memory1, opwrite_memory1, opSel_memory1,
           opReg_memory1, next_PC_select_memory1, instruction_memory1,
           load_data_last, rs1_decode, rs2_decode,
    output ALU_result_writeback, load_data_writeback, opwrite_writeback,
           opSel_writeback, opReg_writeback, next_PC_select_writeback,
           instruction_writeback, bypass_data_last, opwrite_last, opReg_last,
           next_PC_select_last, rs1_fwd_hit, rs2_fwd_hit, rs1_fwd_data,
           rs2_fwd_data, rs1_fwd_stall, rs2_fwd_stall
  );
endinterface

// File: rtl/memory_pipe_stages.sv
// Configurable-depth memory pipe (memory2..memoryN plus writeback) with stall,
// flush and a combinational youngest-first bypass lookup for rs1/rs2.
module memory_pipe_stages #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           MEM_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] NOP        = 32'h00000013
) (
  input  logic               clock,
  input  logic               reset,
  memory_pipe_stages_if.slave bus
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] alu;
    logic                  opwrite;
    logic                  opsel;
    logic [4:0]            opreg;
    logic [1:0]            npc;
    logic [DATA_WIDTH-1:0] instr;
  } stage_t;

  localparam stage_t BUBBLE = '{alu: '0, opwrite: 1'b0, opsel: 1'b0,
                                opreg: 5'd0, npc: 2'b00, instr: NOP};

  stage_t                in_s;
  stage_t                stage_q [2:MEM_STAGES];
  stage_t                stage_d [2:MEM_STAGES];
  stage_t                last_s;
  stage_t                wb_q, wb_d;
  logic [DATA_WIDTH-1:0] load_wb_q, load_wb_d;
  logic                  wb_capture;

  assign in_s = '{alu: bus.ALU_result_memory1, opwrite: bus.opwrite_memory1,
                  opsel: bus.opSel_memory1, opreg: bus.opReg_memory1,
                  npc: bus.next_PC_select_memory1, instr: bus.instruction_memory1};

  // Flush beats stall; memory2 takes memory1, each later stage its predecessor.
  for (genvar k = 2; k <= MEM_STAGES; k++) begin : g_stage
    stage_t src;
    if (k == 2) begin : g_first
      assign src = in_s;
    end else begin : g_next
      assign src = stage_q[k-1];
    end
    assign stage_d[k] = bus.flush ? BUBBLE : (bus.stall ? stage_q[k] : src);
  end

  assign last_s = stage_q[MEM_STAGES];

  // Writeback still retires the pre-flush memoryN entry when flush is set.
  assign wb_capture = bus.flush || !bus.stall;
  assign wb_d       = wb_capture ? last_s : wb_q;
  assign load_wb_d  = wb_capture ? bus.load_data_last : load_wb_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 2; k <= MEM_STAGES; k++) stage_q[k] <= BUBBLE;
      wb_q      <= BUBBLE;
      load_wb_q <= '0;
    end else begin
      stage_q   <= stage_d;
      wb_q      <= wb_d;
      load_wb_q <= load_wb_d;
    end
  end

  assign bus.bypass_data_last         = last_s.opsel ? bus.load_data_last : last_s.alu;
  assign bus.opwrite_last             = last_s.opwrite;
  assign bus.opReg_last               = last_s.opreg;
  assign bus.next_PC_select_last      = last_s.npc;
  assign bus.ALU_result_writeback     = wb_q.alu;
  assign bus.load_data_writeback      = load_wb_q;
  assign bus.opwrite_writeback        = wb_q.opwrite;
  assign bus.opSel_writeback          = wb_q.opsel;
  assign bus.opReg_writeback          = wb_q.opreg;
  assign bus.next_PC_select_writeback = wb_q.npc;
  assign bus.instruction_writeback    = wb_q.instr;

  logic [4:0]            rs        [2];
  logic                  fwd_hit   [2];
  logic                  fwd_stall [2];
  logic [DATA_WIDTH-1:0] fwd_data  [2];

  assign rs[0] = bus.rs1_decode;
  assign rs[1] = bus.rs2_decode;

  // Scan oldest to youngest so the youngest matching stage wins.
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      fwd_hit[p]   = 1'b0;
      fwd_stall[p] = 1'b0;
      fwd_data[p]  = '0;
      if (rs[p] != 5'd0) begin
        if (wb_q.opwrite && wb_q.opreg == rs[p]) begin
          fwd_hit[p]  = 1'b1;
          fwd_data[p] = wb_q.opsel ? load_wb_q : wb_q.alu;
        end
        for (int unsigned k = MEM_STAGES; k >= 2; k--) begin
          if (stage_q[k].opwrite && stage_q[k].opreg == rs[p]) begin
            fwd_hit[p]   = 1'b1;
            fwd_stall[p] = (k != MEM_STAGES) && stage_q[k].opsel;
            fwd_data[p]  = (k == MEM_STAGES) ? bus.bypass_data_last : stage_q[k].alu;
          end
        end
      end
    end
  end

  assign bus.rs1_fwd_hit   = fwd_hit[0];
  assign bus.rs2_fwd_hit   = fwd_hit[1];
  assign bus.rs1_fwd_stall = fwd_stall[0];
  assign bus.rs2_fwd_stall = fwd_stall[1];
  assign bus.rs1_fwd_data  = fwd_data[0];
  assign bus.rs2_fwd_data  = fwd_data[1];

endmodule

// File: tb/tb_memory_pipe_stages.sv
// Directed bench for memory_pipe_stages with MEM_STAGES=3: latency, stall,
// flush-over-stall, load forwarding, priority/x0 and asynchronous reset.
module tb_memory_pipe_stages;
  localparam logic [31:0] NOP_I = 32'h00000013;

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  memory_pipe_stages_if #(.DATA_WIDTH(32)) bus ();

  memory_pipe_stages #(
    .DATA_WIDTH(32),
    .MEM_STAGES(3),
    .NOP       (NOP_I)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic opw, input logic sel, input logic [4:0] rd,
                       input logic [31:0] alu);
    bus.opwrite_memory1        = opw;
    bus.opSel_memory1          = sel;
    bus.opReg_memory1          = rd;
    bus.ALU_result_memory1     = alu;
    bus.next_PC_select_memory1 = opw ? 2'b01 : 2'b00;
    bus.instruction_memory1    = opw ? {20'h0, rd, 7'h33} : NOP_I;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    reset              = 1'b0;
    bus.stall          = 1'b0;
    bus.flush          = 1'b0;
    bus.load_data_last = 32'h0;
    bus.rs1_decode     = 5'd0;
    bus.rs2_decode     = 5'd0;
    idle();
    #12;
    check("reset_instr_wb", bus.instruction_writeback, NOP_I);
    check("reset_alu_wb", bus.ALU_result_writeback, 32'h0);
    check("reset_bypass", bus.bypass_data_last, 32'h0);
    check("reset_opwrite_last", {31'h0, bus.opwrite_last}, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    tick();

    // Latency: three edges from memory1 to writeback.
    drive(1'b1, 1'b0, 5'd5, 32'hDEADBEEF);
    tick();
    idle();
    tick();
    check("lat_early_opreg_wb", {27'h0, bus.opReg_writeback}, 32'd0);
    check("lat_opreg_last", {27'h0, bus.opReg_last}, 32'd5);
    check("lat_npc_last", {30'h0, bus.next_PC_select_last}, 32'd1);
    check("lat_bypass_last", bus.bypass_data_last, 32'hDEADBEEF);
    tick();
    check("lat_opreg_wb", {27'h0, bus.opReg_writeback}, 32'd5);
    check("lat_alu_wb", bus.ALU_result_writeback, 32'hDEADBEEF);
    check("lat_instr_wb", bus.instruction_writeback, 32'h000002B3);
    check("lat_opwrite_wb", {31'h0, bus.opwrite_writeback}, 32'd1);

    // Stall two cycles with the entry in memory2.
    drive(1'b1, 1'b0, 5'd6, 32'h00001111);
    tick();
    idle();
    bus.stall      = 1'b1;
    bus.rs1_decode = 5'd6;
    tick();
    tick();
    check("stall_opreg_last", {27'h0, bus.opReg_last}, 32'd0);
    check("stall_opreg_wb", {27'h0, bus.opReg_writeback}, 32'd0);
    check("stall_fwd_hit", {31'h0, bus.rs1_fwd_hit}, 32'd1);
    check("stall_fwd_data", bus.rs1_fwd_data, 32'h00001111);
    bus.stall = 1'b0;
    tick();
    check("stall_resume_last", {27'h0, bus.opReg_last}, 32'd6);
    check("stall_resume_wb_early", {27'h0, bus.opReg_writeback}, 32'd0);
    tick();
    check("stall_resume_wb", {27'h0, bus.opReg_writeback}, 32'd6);
    bus.rs1_decode = 5'd0;

    // Flush together with stall: memory2/3 bubble, old memory3 retires.
    drive(1'b1, 1'b0, 5'd10, 32'h0000000A);
    tick();
    drive(1'b1, 1'b0, 5'd11, 32'h0000000B);
    tick();
    idle();
    bus.flush = 1'b1;
    bus.stall = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    bus.rs1_decode = 5'd11;
    #1;
    check("flush_wb_opreg", {27'h0, bus.opReg_writeback}, 32'd10);
    check("flush_wb_alu", bus.ALU_result_writeback, 32'h0000000A);
    check("flush_opwrite_last", {31'h0, bus.opwrite_last}, 32'd0);
    check("flush_opreg_last", {27'h0, bus.opReg_last}, 32'd0);
    check("flush_no_hit_b", {31'h0, bus.rs1_fwd_hit}, 32'd0);
    tick();
    check("flush_bubble_wb", bus.instruction_writeback, NOP_I);

    // Load to x7: stall while in memory2, forward load data at memory3.
    drive(1'b1, 1'b1, 5'd7, 32'h00007777);
    tick();
    idle();
    bus.rs1_decode = 5'd7;
    #1;
    check("load_m2_hit", {31'h0, bus.rs1_fwd_hit}, 32'd1);
    check("load_m2_stall", {31'h0, bus.rs1_fwd_stall}, 32'd1);
    check("load_m2_data", bus.rs1_fwd_data, 32'h00007777);
    tick();
    bus.load_data_last = 32'h00001234;
    #1;
    check("load_m3_stall", {31'h0, bus.rs1_fwd_stall}, 32'd0);
    check("load_m3_data", bus.rs1_fwd_data, 32'h00001234);
    check("load_m3_bypass", bus.bypass_data_last, 32'h00001234);
    tick();
    bus.load_data_last = 32'h0;
    #1;
    check("load_wb_data", bus.load_data_writeback, 32'h00001234);
    check("load_wb_fwd", bus.rs1_fwd_data, 32'h00001234);
    check("load_wb_opsel", {31'h0, bus.opSel_writeback}, 32'd1);
    bus.rs1_decode = 5'd0;

    // Priority: x9=1 in memory2 beats x9=2 in writeback.
    drive(1'b1, 1'b0, 5'd9, 32'h2);
    tick();
    idle();
    tick();
    drive(1'b1, 1'b0, 5'd9, 32'h1);
    tick();
    drive(1'b1, 1'b0, 5'd0, 32'h55);
    bus.rs2_decode = 5'd9;
    #1;
    check("prio_wb_alu", bus.ALU_result_writeback, 32'h2);
    check("prio_hit", {31'h0, bus.rs2_fwd_hit}, 32'd1);
    check("prio_data", bus.rs2_fwd_data, 32'h1);
    tick();
    idle();
    bus.rs1_decode = 5'd0;
    #1;
    check("x0_hit", {31'h0, bus.rs1_fwd_hit}, 32'd0);
    check("x0_data", bus.rs1_fwd_data, 32'h0);
    check("prio_m3_data", bus.rs2_fwd_data, 32'h1);

    // Asynchronous reset mid-stream, away from any clock edge.
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("arst_instr_wb", bus.instruction_writeback, NOP_I);
    check("arst_opreg_wb", {27'h0, bus.opReg_writeback}, 32'd0);
    check("arst_alu_wb", bus.ALU_result_writeback, 32'h0);
    check("arst_rs2_hit", {31'h0, bus.rs2_fwd_hit}, 32'd0);
    check("arst_opwrite_last", {31'h0, bus.opwrite_last}, 32'd0);
    check("arst_opreg_last", {27'h0, bus.opReg_last}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/memory_pipe_stages.md
Name: memory_pipe_stages

Overview:
- Parametrised successor to the fixed two-deep memory pipe.
- Carries ALU/load results from the memory1 boundary through a configurable number of memory stages to writeback.
- Adds pipeline stall and flush, plus a built-in bypass/hazard lookup for two decode-side source registers.
- Sits between the memory1 pipe register and the writeback/regfile logic; drives the hazard unit and the decode bypass muxes.

Parameters:
- DATA_WIDTH, 32, datapath and instruction width.
- MEM_STAGES, 2, memory latency in stages from memory1 to last memory stage (legal 2..8). Registered memory stages are memory2..memoryN, where N = MEM_STAGES.
- NOP, 32'h00000013, instruction value inserted on reset and flush.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hold every stage register, writeback included.
- flush  in  1  kill memory2..memoryN contents (replace with bubbles).
- ALU_result_memory1  in  DATA_WIDTH  result entering memory2.
- opwrite_memory1  in  1  regfile write enable.
- opSel_memory1  in  1  1 = load (data from memory), 0 = ALU.
- opReg_memory1  in  5  destination register.
- next_PC_select_memory1  in  2  PC select tag.
- instruction_memory1  in  DATA_WIDTH  instruction tag.
- load_data_last  in  DATA_WIDTH  memory read data, valid aligned with stage memoryN.
- rs1_decode, rs2_decode  in  5  source registers to look up.
- ALU_result_writeback, load_data_writeback  out  DATA_WIDTH  writeback registers.
- opwrite_writeback, opSel_writeback  out  1  writeback registers.
- opReg_writeback  out  5  writeback register.
- next_PC_select_writeback  out  2  writeback register.
- instruction_writeback  out  DATA_WIDTH  writeback register.
- bypass_data_last  out  DATA_WIDTH  opSel_memoryN ? load_data_last : ALU_result_memoryN.
- opwrite_last  out  1  memoryN fields, for the external hazard unit.
- opReg_last  out  5  memoryN fields, for the external hazard unit.
- next_PC_select_last  out  2  memoryN fields, for the external hazard unit.
- rs1_fwd_hit, rs2_fwd_hit  out  1  a stage or writeback holds a pending write to rsX.
- rs1_fwd_data, rs2_fwd_data  out  DATA_WIDTH  forwarded value.
- rs1_fwd_stall, rs2_fwd_stall  out  1  youngest match is a load not yet at memoryN.

Behaviour:
- Reset (reset low, async assert, sync-safe deassert): all stage and writeback registers cleared.
  - Data fields 0, opwrite/opSel 0, opReg 0, next_PC_select 2'b00, instruction NOP.
  - Consequently all fwd outputs are 0 and bypass_data_last is 0.
  - Reset mid-operation discards all in-flight entries immediately.
- Normal advance (stall=0, flush=0): memory2 <= memory1 inputs; memoryK <= memoryK-1 for K = 3..N; writeback <= memoryN.
  - load_data_writeback <= load_data_last.
  - Latency memory1 -> writeback is MEM_STAGES clocks.
  - With MEM_STAGES=2, timing is identical to the legacy two-stage pipe.
- Stall=1, flush=0: every register holds. Writeback outputs stay stable; a repeated regfile write of the same value is acceptable.
- Flush=1: memory2..memoryN load bubbles (opwrite 0, opSel 0, opReg 0, next_PC_select 0, data 0, instruction NOP).
  - Writeback still captures the pre-flush memoryN, so the oldest entry retires.
  - Flush overrides stall when both are asserted.
- Bypass lookup is combinational, evaluated independently for rs1 and rs2.
  - A candidate matches when opwrite=1, opReg==rsX and rsX!=0.
  - Priority is youngest first: memory2, memory3, ..., memoryN, then writeback. Only the youngest match is used.
  - Match at memoryK (K<N) with opSel=0: hit=1, stall=0, data=ALU_result_memoryK.
  - Match at memoryK (K<N) with opSel=1: hit=1, stall=1, data=ALU_result_memoryK (don't-care value, but driven deterministically).
  - Match at memoryN: hit=1, stall=0, data=bypass_data_last.
  - Match at writeback: hit=1, stall=0, data=opSel_writeback ? load_data_writeback : ALU_result_writeback.
  - No match, or rsX=0: hit=0, stall=0, data=0.
- Stage arrays are indexed by a generate loop. No behaviour depends on DATA_WIDTH other than field width.

Test Plan:
- Reset: assert reset low mid-stream with MEM_STAGES=3 -> all writeback outputs 0, instruction_writeback=32'h00000013, rs1_fwd_hit=0, within the same cycle (async).
- Latency: MEM_STAGES=3; ALU op opReg=5, ALU_result=32'hDEAD_BEEF, opwrite=1 at cycle 0 -> opReg_writeback=5 and ALU_result_writeback=32'hDEADBEEF after the 3rd rising edge, not earlier.
- Stall: raise stall for 2 cycles while the entry sits in memory2 -> all outputs frozen; writeback arrival delayed by exactly 2 cycles.
- Flush vs stall: flush=1 and stall=1 together with entries in memory2/memory3 -> memory2..3 become NOP bubbles; writeback takes the old memory3 entry; opwrite_last=0 next cycle.
- Load hazard forwarding: MEM_STAGES=3, load to x7 in memory2, rs1_decode=7 -> rs1_fwd_hit=1, rs1_fwd_stall=1. One cycle later (memory3), load_data_last=32'h1234 -> stall=0, rs1_fwd_data=32'h1234.
- Priority/x0: ALU write x9=1 in memory2 and x9=2 in writeback, rs2_decode=9 -> rs2_fwd_data=1. Any write to x0 with rs1_decode=0 -> rs1_fwd_hit=0.
